sysid_checker: RTL and testbench



---
 rtl/sysid_checker_pkg.sv | 21 ++
 rtl/sysid_read_port.sv | 60 ++++++
 rtl/sysid_checker.sv | 162 ++++++++++++++++
 tb/tb_sysid_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// slave word addresses and the width of the gap / recheck counters.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    AUTO,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    EVAL,
    GAP,
    DONE
  } state_t;

  localparam logic ID_ADDR = 1'b0;
  localparam logic TS_ADDR = 1'b1;

  localparam int CNT_W = 24;

endpackage

// File: rtl/sysid_read_port.sv
// Single Avalon-MM read: holds the strobe through waitrequest, then flags
// the cycle in which readdata is valid after READ_LATENCY cycles.
module sysid_read_port #(
  parameter int READ_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic        addr,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        m_read,
  output logic        m_address,
  output logic        accepted,
  output logic        rvalid,
  output logic [31:0] rdata
);

  logic addr_q;

  // NOTE: m_read is a pure decode of the FSM state register, so it falls as
  // soon as reset_n resets that register -- no clock edge is needed.
  assign m_read    = go;
  assign m_address = go ? addr : addr_q;
  assign accepted  = go & ~m_waitrequest;
  assign rdata     = m_readdata;

  // Remember the last address so the bus does not toggle between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= 1'b0;
    end else if (go) begin
      // NOTE: clocked state always uses non-blocking assignment so every
      // register samples values from before the edge.
      addr_q <= addr;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign rvalid = accepted;
    end else begin : g_latn
      logic [1:0] lat_cnt;

      // Loaded with the latency at accept; data is valid when it reaches 1.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          lat_cnt <= 2'd0;
        end else if (accepted) begin
          lat_cnt <= 2'(READ_LATENCY);
        end else if (lat_cnt != 2'd0) begin
          lat_cnt <= lat_cnt - 2'd1;
        end
      end

      assign rvalid = (lat_cnt == 2'd1);
    end
  endgenerate

endmodule

// File: rtl/sysid_checker.sv
// Power-up / on-demand check of the system-ID slave: reads ID and timestamp,
// compares against expected constants, retries, and publishes sticky status.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd875064246,
  parameter logic [31:0] EXPECTED_TS    = 32'd1278596268,
  parameter int          READ_LATENCY   = 0,
  parameter int          MAX_RETRIES    = 3,
  parameter int          RETRY_GAP      = 16,
  parameter int          RECHECK_PERIOD = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        fail,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [1:0]  retry_count
);

  localparam logic [1:0]       MAX_RETRY_CNT = 2'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'(RETRY_GAP - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST   =
    CNT_W'((RECHECK_PERIOD == 0) ? 0 : RECHECK_PERIOD - 1);

  state_t           state;
  logic [31:0]      rd_id;
  logic [31:0]      rd_ts;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] period_cnt;

  logic        go;
  logic        port_addr;
  logic        accepted;
  logic        rvalid;
  logic [31:0] rdata;
  logic        id_match;
  logic        ts_match;
  logic        period_hit;

  assign go        = (state == RD_ID) || (state == RD_TS);
  assign port_addr = ((state == RD_TS) || (state == WAIT_TS)) ? TS_ADDR : ID_ADDR;

  sysid_read_port #(
    .READ_LATENCY (READ_LATENCY)
  ) u_read_port (
    .clock         (clock),
    .reset_n       (reset_n),
    .go            (go),
    .addr          (port_addr),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .m_read        (m_read),
    .m_address     (m_address),
    .accepted      (accepted),
    .rvalid        (rvalid),
    .rdata         (rdata)
  );

  assign id_match   = (rd_id == EXPECTED_ID);
  assign ts_match   = (rd_ts == EXPECTED_TS);
  assign period_hit = (RECHECK_PERIOD != 0) && (period_cnt == PERIOD_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= AUTO;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      fail        <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
      retry_count <= 2'd0;
      rd_id       <= '0;
      rd_ts       <= '0;
      gap_cnt     <= '0;
      period_cnt  <= '0;
    end else begin
      unique case (state)
        AUTO: begin
          state <= RD_ID;
          busy  <= 1'b1;
        end

        // accepted is never set in WAIT_* because the strobe is low there.
        RD_ID, WAIT_ID: begin
          if (rvalid) begin
            rd_id <= rdata;
            state <= RD_TS;
          end else if (accepted) begin
            state <= WAIT_ID;
          end
        end

        RD_TS, WAIT_TS: begin
          if (rvalid) begin
            rd_ts <= rdata;
            state <= EVAL;
          end else if (accepted) begin
            state <= WAIT_TS;
          end
        end

        EVAL: begin
          captured_id <= rd_id;
          captured_ts <= rd_ts;
          id_ok       <= id_match;
          ts_ok       <= ts_match;
          if (id_match && ts_match) begin
            fail       <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            period_cnt <= '0;
            state      <= DONE;
          end else if (retry_count < MAX_RETRY_CNT) begin
            retry_count <= retry_count + 2'd1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            fail       <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            period_cnt <= '0;
            state      <= DONE;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= RD_ID;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        // A start pulse coinciding with timer expiry launches one check.
        DONE: begin
          if (start || period_hit) begin
            retry_count <= 2'd0;
            busy        <= 1'b1;
            state       <= RD_ID;
          end else if (RECHECK_PERIOD != 0) begin
            period_cnt <= period_cnt + 1'b1;
          end
        end

        default: state <= AUTO;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: dut0 has zero read latency and a
// 100-cycle recheck period, dut1 has a two-cycle read latency and a stalling slave.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd875064246;
  localparam logic [31:0] EXP_TS = 32'd1278596268;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // dut0 side
  logic        rst0_n, start0, wait0;
  logic [31:0] id0_val, ts0_val, rdata0;
  logic        m_address0, m_read0, busy0, done0, id_ok0, ts_ok0, fail0;
  logic [31:0] captured_id0, captured_ts0;
  logic [1:0]  retry_count0;

  // dut1 side
  logic        rst1_n, start1, wait1;
  logic [31:0] rdata1;
  logic        m_address1, m_read1, busy1, done1, id_ok1, ts_ok1, fail1;
  logic [31:0] captured_id1, captured_ts1;
  logic [1:0]  retry_count1;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int age1   = 0;
  int stall_left1 = 0;

  assign rdata0 = m_address0 ? ts0_val : id0_val;

  sysid_checker #(
    .READ_LATENCY(0), .MAX_RETRIES(3), .RETRY_GAP(16), .RECHECK_PERIOD(100)
  ) dut0 (
    .clock(clock), .reset_n(rst0_n), .start(start0),
    .m_address(m_address0), .m_read(m_read0), .m_waitrequest(wait0),
    .m_readdata(rdata0), .busy(busy0), .done(done0), .id_ok(id_ok0),
    .ts_ok(ts_ok0), .fail(fail0), .captured_id(captured_id0),
    .captured_ts(captured_ts0), .retry_count(retry_count0)
  );

  sysid_checker #(
    .READ_LATENCY(2), .MAX_RETRIES(0), .RETRY_GAP(16), .RECHECK_PERIOD(0)
  ) dut1 (
    .clock(clock), .reset_n(rst1_n), .start(start1),
    .m_address(m_address1), .m_read(m_read1), .m_waitrequest(wait1),
    .m_readdata(rdata1), .busy(busy1), .done(done1), .id_ok(id_ok1),
    .ts_ok(ts_ok1), .fail(fail1), .captured_id(captured_id1),
    .captured_ts(captured_ts1), .retry_count(retry_count1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock; afterwards drive dut1's slave: stall while stall_left1 > 0,
  // and present correct data only two cycles after the accept.
  task automatic tick();
    logic acc1;
    acc1 = m_read1 && !wait1;
    if (m_read1 && wait1 && stall_left1 > 0) stall_left1--;
    @(posedge clock);
    #1;
    cyc++;
    if (acc1) age1 = 1;
    else if (age1 == 1) age1 = 2;
    else age1 = 0;
    wait1  = m_read1 && (stall_left1 > 0);
    rdata1 = (age1 == 2) ? (m_address1 ? EXP_TS : EXP_ID) : (32'hBAD00000 + 32'(cyc));
  endtask

  task automatic reset0();
    rst0_n = 1'b0;
    tick();
    tick();
    rst0_n = 1'b1;
  endtask

  task automatic check_reset0(input string tag);
    check(tag, {m_read0, m_address0, busy0, done0, id_ok0, ts_ok0, fail0, retry_count0}, 32'd0);
    check({tag, " captured_id"}, captured_id0, 32'd0);
    check({tag, " captured_ts"}, captured_ts0, 32'd0);
  endtask

  task automatic wait_idle0(input string tag, input int budget);
    int used;
    used = 0;
    while ((busy0 || !done0) && used < budget) begin
      tick();
      used++;
    end
    check({tag, " reached DONE"}, {busy0, done0}, 2'b01);
  endtask

  typedef struct packed {
    logic m_read;
    logic m_addr;
    logic busy;
    logic done;
    logic id_ok;
    logic ts_ok;
    logic fail;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int attempts, idle, reads, busy_cnt, waited, stalled, used;
    logic held, addr_ok;

    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    wait0  = 1'b0; wait1  = 1'b0;
    id0_val = EXP_ID; ts0_val = EXP_TS;
    rdata1 = 32'd0;

    // Reset state.
    tick();
    check_reset0("reset");

    // Test 1: clean check, one row per cycle after release (AUTO..DONE).
    tbl[0] = '{m_read:0, m_addr:0, busy:1'bx, done:0, id_ok:0, ts_ok:0, fail:0};
    tbl[1] = '{m_read:1, m_addr:0, busy:1,    done:0, id_ok:0, ts_ok:0, fail:0};
    tbl[2] = '{m_read:1, m_addr:1, busy:1,    done:0, id_ok:0, ts_ok:0, fail:0};
    tbl[3] = '{m_read:0, m_addr:1, busy:1,    done:0, id_ok:0, ts_ok:0, fail:0};
    tbl[4] = '{m_read:0, m_addr:1, busy:0,    done:1, id_ok:1, ts_ok:1, fail:0};
    reset0();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check($sformatf("t1[%0d] m_read", i), m_read0, tbl[i].m_read);
      check($sformatf("t1[%0d] m_address", i), m_address0, tbl[i].m_addr);
      if (!$isunknown(tbl[i].busy)) check($sformatf("t1[%0d] busy", i), busy0, tbl[i].busy);
      check($sformatf("t1[%0d] done", i), done0, tbl[i].done);
      check($sformatf("t1[%0d] id_ok/ts_ok/fail", i), {id_ok0, ts_ok0, fail0},
            {tbl[i].id_ok, tbl[i].ts_ok, tbl[i].fail});
    end
    check("t1 retry_count", retry_count0, 2'd0);
    check("t1 captured_id", captured_id0, EXP_ID);
    check("t1 captured_ts", captured_ts0, EXP_TS);

    // Test 2: ID always wrong; idle between attempts is EVAL + 16 GAP cycles.
    id0_val = 32'd0;
    reset0();
    attempts = 0;
    idle = 0;
    for (int i = 0; i < 400 && !(done0 && !busy0); i++) begin
      tick();
      if (m_read0 && m_address0 == 1'b0) begin
        if (attempts > 0) check($sformatf("t2 idle before attempt %0d", attempts + 1), idle, 17);
        attempts++;
        idle = 0;
      end else if (!m_read0) begin
        idle++;
      end
    end
    check("t2 attempts", attempts, 4);
    check("t2 done/busy", {done0, busy0}, 2'b10);
    check("t2 id_ok/ts_ok/fail", {id_ok0, ts_ok0, fail0}, 3'b011);
    check("t2 retry_count", retry_count0, 2'd3);
    check("t2 captured_id", captured_id0, 32'd0);
    check("t2 captured_ts", captured_ts0, EXP_TS);

    // Test 3: ID wrong on the first attempt only.
    id0_val = 32'd0;
    reset0();
    waited = 0;
    while (retry_count0 != 2'd1 && waited < 40) begin
      tick();
      waited++;
    end
    check("t3 first retry taken", retry_count0, 2'd1);
    id0_val = EXP_ID;
    wait_idle0("t3", 100);
    check("t3 id_ok/ts_ok/fail", {id_ok0, ts_ok0, fail0}, 3'b110);
    check("t3 retry_count", retry_count0, 2'd1);

    // Test 5: now in DONE cycle 0; start lands on the timer-expiry cycle 99.
    repeat (99) tick();
    check("t5 idle until expiry", busy0, 1'b0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t5 busy after start", busy0, 1'b1);
    check("t5 retry_count cleared", retry_count0, 2'd0);
    reads = m_read0 ? 1 : 0;
    held = 1'b1;
    start0 = 1'b1;  // start while busy must be ignored
    tick();
    start0 = 1'b0;
    if (m_read0) reads++;
    for (int i = 0; i < 20 && busy0; i++) begin
      tick();
      if (m_read0) reads++;
      if (id_ok0 !== 1'b1) held = 1'b0;
    end
    check("t5 read cycles", reads, 2);
    check("t5 id_ok held", held, 1'b1);
    check("t5 done/busy", {done0, busy0}, 2'b10);
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy0) busy_cnt++;
    end
    check("t5 no extra check", busy_cnt, 0);
    used = 50;
    while (!busy0 && used < 200) begin
      tick();
      used++;
    end
    check("t5 periodic recheck delay", used, 100);

    // Test 6: reset asserted in RD_TS drops m_read without a clock edge.
    reset0();
    tick();
    tick();
    check("t6 in RD_TS", {m_read0, m_address0}, 2'b11);
    rst0_n = 1'b0;
    #1;
    check_reset0("t6 async reset");
    tick();
    rst0_n = 1'b1;
    tick();
    check("t6 restart at ID", {m_read0, m_address0}, 2'b10);
    tick();
    check("t6 then TS", {m_read0, m_address0}, 2'b11);

    // Test 4: dut1, five stall cycles on address 0, data valid at accept+2.
    stall_left1 = 5;
    tick();
    rst1_n = 1'b1;
    stalled = 0;
    reads = 0;
    used = 0;
    addr_ok = 1'b1;
    while (!(done1 && !busy1) && used < 60) begin
      tick();
      used++;
      if (m_read1) reads++;
      if (m_read1 && wait1) begin
        stalled++;
        if (m_address1 !== 1'b0) addr_ok = 1'b0;
      end
    end
    check("t4 stall cycles", stalled, 5);
    check("t4 address held in stall", addr_ok, 1'b1);
    check("t4 read cycles", reads, 7);
    check("t4 cycles to DONE", used, 13);
    check("t4 captured_id", captured_id1, EXP_ID);
    check("t4 captured_ts", captured_ts1, EXP_TS);
    check("t4 id_ok/ts_ok/fail", {id_ok1, ts_ok1, fail1}, 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
